// File: rtl/uart_bus_responder_if.sv
// uart_bus_responder_if
//   Strobe handshake and status signals between the CPU memory controller
//   and the UART responder. The shared data byte itself is a separate inout
//   port on the responder so that tristate resolution stays on a plain net.
//   rdn, wrn             : read / write strobes, active low (controller drives)
//   data_ready           : received byte waiting in the RX holding register
//   tbre, tsre           : TX holding register empty / TX shift register empty
//   rx_overrun           : sticky, unread byte was overwritten
//   frame_err            : one-cycle pulse, stop bit sampled low
interface uart_bus_responder_if;
  logic rdn;
  logic wrn;
  logic data_ready;
  logic tbre;
  logic tsre;
  logic rx_overrun;
  logic frame_err;

  modport master (
    output rdn, wrn,
    input  data_ready, tbre, tsre, rx_overrun, frame_err
  );

  modport slave (
    input  rdn, wrn,
    output data_ready, tbre, tsre, rx_overrun, frame_err
  );
endinterface

// File: rtl/uart_bus_responder.sv
// uart_bus_responder
//   Device-side 8N1 UART answering the memory controller's strobe handshake.
//   A byte written on the shared bus (latched on the wrn rising edge) is sent
//   on o_txd; frames arriving on i_rxd are assembled into a holding register
//   that the controller reads by pulling rdn low.
//   i_clk        : system clock, rising edge
//   i_rst        : asynchronous reset, active low
//   io_bus       : strobes in / status out (slave modport)
//   io_bus_data  : shared data bus low byte, driven only while rdn is low
//   i_rxd        : asynchronous serial input
//   o_txd        : serial output, idle high
module uart_bus_responder #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  uart_bus_responder_if.slave   io_bus,
  inout  wire  [7:0]            io_bus_data,
  input  logic                  i_rxd,
  output logic                  o_txd
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // synchronisers plus one extra stage each for edge detection
  logic [1:0] r_rdn_sync, r_wrn_sync, r_rxd_sync;
  logic       r_rdn_d, r_wrn_d, r_rxd_d;
  logic       w_rd_rise, w_wr_rise, w_rx_fall, w_rx_s;

  // TX side
  state_t          r_tx_state, w_tx_state_nx;
  logic [CW-1:0]   r_tx_cnt, w_tx_cnt_nx;
  logic [2:0]      r_tx_bit, w_tx_bit_nx;
  logic [7:0]      r_tx_shift, w_tx_shift_nx;
  logic [7:0]      r_tx_hold;
  logic            r_tbre, r_tsre, w_tsre_nx, r_txd, w_txd_nx, w_tx_load;

  // RX side
  state_t          r_rx_state, w_rx_state_nx;
  logic [CW-1:0]   r_rx_cnt, w_rx_cnt_nx;
  logic [2:0]      r_rx_bit, w_rx_bit_nx;
  logic [7:0]      r_rx_shift, w_rx_shift_nx;
  logic [7:0]      r_rx_hold;
  logic            r_data_ready, r_rx_overrun, r_frame_err;
  logic            w_rx_ok, w_rx_bad;

  logic            w_bus_oe;

  // Raw rdn gates the bus so data is valid for the whole low phase,
  // independent of synchroniser latency.
  assign w_bus_oe    = ~io_bus.rdn;
  assign io_bus_data = w_bus_oe ? r_rx_hold : 8'hzz;

  assign w_rd_rise = r_rdn_sync[1] & ~r_rdn_d;
  assign w_wr_rise = r_wrn_sync[1] & ~r_wrn_d;
  assign w_rx_fall = r_rxd_d & ~r_rxd_sync[1];
  assign w_rx_s    = r_rxd_sync[1];

  assign io_bus.data_ready = r_data_ready;
  assign io_bus.tbre       = r_tbre;
  assign io_bus.tsre       = r_tsre;
  assign io_bus.rx_overrun = r_rx_overrun;
  assign io_bus.frame_err  = r_frame_err;
  assign o_txd             = r_txd;

  // Input synchronisers and edge-detect history (idle level is high).
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rdn_sync <= 2'b11;
      r_wrn_sync <= 2'b11;
      r_rxd_sync <= 2'b11;
      r_rdn_d    <= 1'b1;
      r_wrn_d    <= 1'b1;
      r_rxd_d    <= 1'b1;
    end else begin
      r_rdn_sync <= {r_rdn_sync[0], io_bus.rdn};
      r_wrn_sync <= {r_wrn_sync[0], io_bus.wrn};
      r_rxd_sync <= {r_rxd_sync[0], i_rxd};
      r_rdn_d    <= r_rdn_sync[1];
      r_wrn_d    <= r_wrn_sync[1];
      r_rxd_d    <= r_rxd_sync[1];
    end
  end

  // TX next-state: baud counter, bit counter, shifter and line level.
  always_comb begin
    w_tx_state_nx = r_tx_state;
    w_tx_cnt_nx   = r_tx_cnt;
    w_tx_bit_nx   = r_tx_bit;
    w_tx_shift_nx = r_tx_shift;
    w_tsre_nx     = r_tsre;
    w_txd_nx      = r_txd;
    w_tx_load     = 1'b0;
    case (r_tx_state)
      ST_IDLE: begin
        w_tx_cnt_nx = CNT_ZERO;
        w_txd_nx    = 1'b1;
        if (!r_tbre) begin
          w_tx_load     = 1'b1;
          w_tx_shift_nx = r_tx_hold;
          w_tsre_nx     = 1'b0;
          w_txd_nx      = 1'b0;
          w_tx_state_nx = ST_START;
        end else begin
          w_tsre_nx = 1'b1;
        end
      end
      ST_START: begin
        if (r_tx_cnt == CNT_MAX) begin
          w_tx_cnt_nx   = CNT_ZERO;
          w_tx_bit_nx   = 3'd0;
          w_txd_nx      = r_tx_shift[0];
          w_tx_state_nx = ST_DATA;
        end else begin
          w_tx_cnt_nx = r_tx_cnt + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (r_tx_cnt == CNT_MAX) begin
          w_tx_cnt_nx = CNT_ZERO;
          if (r_tx_bit == 3'd7) begin
            w_txd_nx      = 1'b1;
            w_tx_state_nx = ST_STOP;
          end else begin
            w_tx_bit_nx   = r_tx_bit + 3'd1;
            w_tx_shift_nx = {1'b0, r_tx_shift[7:1]};
            w_txd_nx      = r_tx_shift[1];
          end
        end else begin
          w_tx_cnt_nx = r_tx_cnt + CNT_ONE;
        end
      end
      ST_STOP: begin
        if (r_tx_cnt == CNT_MAX) begin
          w_tx_cnt_nx = CNT_ZERO;
          // A byte already waiting goes out with no idle gap.
          if (!r_tbre) begin
            w_tx_load     = 1'b1;
            w_tx_shift_nx = r_tx_hold;
            w_txd_nx      = 1'b0;
            w_tx_state_nx = ST_START;
          end else begin
            w_tsre_nx     = 1'b1;
            w_txd_nx      = 1'b1;
            w_tx_state_nx = ST_IDLE;
          end
        end else begin
          w_tx_cnt_nx = r_tx_cnt + CNT_ONE;
        end
      end
      default: begin
        w_tx_cnt_nx   = CNT_ZERO;
        w_tsre_nx     = 1'b1;
        w_txd_nx      = 1'b1;
        w_tx_state_nx = ST_IDLE;
      end
    endcase
  end

  // TX state register; reset forces the line idle immediately.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_tx_state <= ST_IDLE;
      r_tx_cnt   <= CNT_ZERO;
      r_tx_bit   <= 3'd0;
      r_tx_shift <= 8'h00;
      r_tsre     <= 1'b1;
      r_txd      <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nx;
      r_tx_cnt   <= w_tx_cnt_nx;
      r_tx_bit   <= w_tx_bit_nx;
      r_tx_shift <= w_tx_shift_nx;
      r_tsre     <= w_tsre_nx;
      r_txd      <= w_txd_nx;
    end
  end

  // TX holding register; a write wins over a same-cycle load so tbre ends 0.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_tx_hold <= 8'h00;
      r_tbre    <= 1'b1;
    end else if (w_wr_rise) begin
      r_tx_hold <= io_bus_data;
      r_tbre    <= 1'b0;
    end else if (w_tx_load) begin
      r_tbre    <= 1'b1;
    end else begin
      r_tbre    <= r_tbre;
    end
  end

  // RX next-state: start validation at half bit, then full-bit sampling.
  always_comb begin
    w_rx_state_nx = r_rx_state;
    w_rx_cnt_nx   = r_rx_cnt;
    w_rx_bit_nx   = r_rx_bit;
    w_rx_shift_nx = r_rx_shift;
    w_rx_ok       = 1'b0;
    w_rx_bad      = 1'b0;
    case (r_rx_state)
      ST_IDLE: begin
        w_rx_cnt_nx = CNT_ZERO;
        w_rx_bit_nx = 3'd0;
        if (w_rx_fall) begin
          w_rx_state_nx = ST_START;
        end else begin
          w_rx_state_nx = ST_IDLE;
        end
      end
      ST_START: begin
        if (r_rx_cnt == CNT_HALF) begin
          w_rx_cnt_nx = CNT_ZERO;
          if (w_rx_s) begin
            w_rx_state_nx = ST_IDLE;
          end else begin
            w_rx_state_nx = ST_DATA;
          end
        end else begin
          w_rx_cnt_nx = r_rx_cnt + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (r_rx_cnt == CNT_MAX) begin
          w_rx_cnt_nx   = CNT_ZERO;
          w_rx_shift_nx = {w_rx_s, r_rx_shift[7:1]};
          if (r_rx_bit == 3'd7) begin
            w_rx_state_nx = ST_STOP;
          end else begin
            w_rx_bit_nx = r_rx_bit + 3'd1;
          end
        end else begin
          w_rx_cnt_nx = r_rx_cnt + CNT_ONE;
        end
      end
      ST_STOP: begin
        if (r_rx_cnt == CNT_MAX) begin
          w_rx_cnt_nx   = CNT_ZERO;
          w_rx_state_nx = ST_IDLE;
          if (w_rx_s) begin
            w_rx_ok = 1'b1;
          end else begin
            w_rx_bad = 1'b1;
          end
        end else begin
          w_rx_cnt_nx = r_rx_cnt + CNT_ONE;
        end
      end
      default: begin
        w_rx_cnt_nx   = CNT_ZERO;
        w_rx_state_nx = ST_IDLE;
      end
    endcase
  end

  // RX state register; reset discards any partial byte.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rx_state <= ST_IDLE;
      r_rx_cnt   <= CNT_ZERO;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'h00;
    end else begin
      r_rx_state <= w_rx_state_nx;
      r_rx_cnt   <= w_rx_cnt_nx;
      r_rx_bit   <= w_rx_bit_nx;
      r_rx_shift <= w_rx_shift_nx;
    end
  end

  // RX holding register and status; completion beats a same-cycle read-clear.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rx_hold    <= 8'h00;
      r_data_ready <= 1'b0;
      r_rx_overrun <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_frame_err <= w_rx_bad;
      if (w_rx_ok) begin
        r_rx_hold    <= r_rx_shift;
        r_data_ready <= 1'b1;
        if (w_rd_rise) begin
          r_rx_overrun <= 1'b0;
        end else if (r_data_ready) begin
          r_rx_overrun <= 1'b1;
        end else begin
          r_rx_overrun <= r_rx_overrun;
        end
      end else if (w_rd_rise) begin
        r_data_ready <= 1'b0;
        r_rx_overrun <= 1'b0;
      end else begin
        r_data_ready <= r_data_ready;
        r_rx_overrun <= r_rx_overrun;
      end
    end
  end

endmodule

// File: tb/tb_uart_bus_responder.sv
// tb_uart_bus_responder
//   Self-checking bench for uart_bus_responder at CLKS_PER_BIT=16.
//   Expected TX line levels and expected RX read bytes are queued when the
//   stimulus is applied and popped when the DUT output is sampled.
module tb_uart_bus_responder;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       txd;
  logic [7:0] tb_drv;
  logic       tb_en;
  wire  [7:0] bus_data;

  assign bus_data = tb_en ? tb_drv : 8'hzz;

  uart_bus_responder_if bus_if();

  uart_bus_responder #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .io_bus      (bus_if),
    .io_bus_data (bus_data),
    .i_rxd       (rxd),
    .o_txd       (txd)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         ferr_cnt = 0;
  logic       tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] last_hold = 8'h00;

  // count cycles in which frame_err is high
  always @(negedge clk) begin
    if (bus_if.frame_err === 1'b1) ferr_cnt = ferr_cnt + 1;
  end

  task automatic push_frame(input logic [7:0] b);
    tx_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) tx_q.push_back(b[i]);
    tx_q.push_back(1'b1);
  endtask

  // Returns one cycle after the edge on which the TX load happens.
  task automatic write_byte(input logic [7:0] b, input bit chk);
    @(posedge clk); #1;
    tb_drv = b; tb_en = 1'b1; bus_if.wrn = 1'b0;
    repeat (4) @(posedge clk);
    #1 bus_if.wrn = 1'b1;
    repeat (3) @(posedge clk);
    if (chk) begin
      @(negedge clk);
      checks++;
      if (bus_if.tbre !== 1'b0) begin
        errors++; $display("FAIL wr_tbre_low: got %b want 0", bus_if.tbre);
      end
    end
    @(posedge clk); #1;
    if (chk) begin
      checks++;
      if (bus_if.tbre !== 1'b1 || bus_if.tsre !== 1'b0 || txd !== 1'b0) begin
        errors++;
        $display("FAIL wr_load: tbre/tsre/txd got %b%b%b want 100", bus_if.tbre, bus_if.tsre, txd);
      end
    end
    tb_en = 1'b0;
  endtask

  // Frame start is the edge just before the call; samples mid-bit.
  task automatic monitor_tx(input int nbits);
    int   done;
    logic exp;
    done = 0;
    for (int i = 0; i < nbits; i++) begin
      repeat (16 * i + 8 - done) @(posedge clk);
      done = 16 * i + 8;
      @(negedge clk);
      checks++;
      if (tx_q.size() == 0) begin
        errors++; $display("FAIL tx_queue_empty: bit %0d has no expectation", i);
      end else begin
        exp = tx_q.pop_front();
        if (txd !== exp || bus_if.tsre !== 1'b0) begin
          errors++;
          $display("FAIL tx_bit%0d: txd=%b tsre=%b want txd=%b tsre=0", i, txd, bus_if.tsre, exp);
        end
      end
    end
    repeat (16 * nbits - 1 - done) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus_if.tsre !== 1'b0) begin
      errors++; $display("FAIL tsre_early: got %b want 0 at cycle %0d", bus_if.tsre, 16 * nbits - 1);
    end
    @(negedge clk);
    checks++;
    if (bus_if.tsre !== 1'b1 || txd !== 1'b1) begin
      errors++; $display("FAIL tsre_end: tsre=%b txd=%b want 1 1", bus_if.tsre, txd);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    if (stop) begin
      // single holding register: an unread byte is overwritten
      if (rx_q.size() > 0) void'(rx_q.pop_back());
      rx_q.push_back(b);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1 rxd = fr[i];
      repeat (CPB - 1) @(posedge clk);
    end
    @(posedge clk); #1 rxd = 1'b1;
  endtask

  task automatic read_check(input string nm);
    logic [7:0] exp;
    if (rx_q.size() > 0) begin
      exp = rx_q.pop_front();
      last_hold = exp;
    end else begin
      exp = last_hold;
    end
    @(posedge clk); #1 bus_if.rdn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus_data !== exp) begin
      errors++; $display("FAIL %s_data: got %h want %h", nm, bus_data, exp);
    end
    @(posedge clk); #1 bus_if.rdn = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus_if.data_ready !== 1'b0 || bus_if.rx_overrun !== 1'b0) begin
      errors++;
      $display("FAIL %s_clear: ready=%b overrun=%b want 0 0", nm, bus_if.data_ready, bus_if.rx_overrun);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; rxd = 1'b1; tb_en = 1'b0; tb_drv = 8'h00;
    bus_if.rdn = 1'b1; bus_if.wrn = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (txd !== 1'b1 || bus_if.tbre !== 1'b1 || bus_if.tsre !== 1'b1 ||
        bus_if.data_ready !== 1'b0 || bus_if.rx_overrun !== 1'b0 || bus_if.frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: txd/tbre/tsre/ready/ovr/ferr=%b%b%b%b%b%b want 111000",
               txd, bus_if.tbre, bus_if.tsre, bus_if.data_ready, bus_if.rx_overrun, bus_if.frame_err);
    end
    checks++;
    if (dut.w_bus_oe !== 1'b0) begin
      errors++; $display("FAIL reset_bus_oe: got %b want 0 (bus high-Z)", dut.w_bus_oe);
    end
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    // abort a frame of zeros in the middle of a data bit
    write_byte(8'h00, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (txd !== 1'b0) begin
      errors++; $display("FAIL midframe_pre: txd=%b want 0", txd);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (txd !== 1'b1 || bus_if.tsre !== 1'b1 || bus_if.tbre !== 1'b1) begin
      errors++;
      $display("FAIL midframe_reset: txd/tsre/tbre=%b%b%b want 111", txd, bus_if.tsre, bus_if.tbre);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++;
    if (txd !== 1'b1 || bus_if.tsre !== 1'b1) begin
      errors++; $display("FAIL post_reset_idle: txd=%b tsre=%b want 1 1", txd, bus_if.tsre);
    end
  endtask

  task automatic test_tx_single();
    push_frame(8'hA5);
    write_byte(8'hA5, 1'b1);
    monitor_tx(10);
    repeat (5) @(posedge clk);
  endtask

  task automatic test_back_to_back();
    push_frame(8'h3C);
    write_byte(8'h3C, 1'b1);
    fork
      monitor_tx(20);
      begin
        push_frame(8'hC3);
        write_byte(8'hC3, 1'b0);
      end
    join
    repeat (5) @(posedge clk);
  endtask

  task automatic test_rx_read();
    int f0;
    f0 = ferr_cnt;
    send_rx(8'h5A, 1'b1);
    @(negedge clk);
    checks++;
    if (bus_if.data_ready !== 1'b1 || bus_if.rx_overrun !== 1'b0) begin
      errors++;
      $display("FAIL rx_ready: ready=%b overrun=%b want 1 0", bus_if.data_ready, bus_if.rx_overrun);
    end
    read_check("rx_5a");
    checks++;
    if (ferr_cnt != f0) begin
      errors++; $display("FAIL rx_no_ferr: pulses=%0d want 0", ferr_cnt - f0);
    end
  endtask

  task automatic test_overrun_frame_err();
    int f0;
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    @(negedge clk);
    checks++;
    if (bus_if.data_ready !== 1'b1 || bus_if.rx_overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_flag: ready=%b overrun=%b want 1 1", bus_if.data_ready, bus_if.rx_overrun);
    end
    read_check("overrun");
    f0 = ferr_cnt;
    send_rx(8'h77, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ferr_cnt - f0 != 1) begin
      errors++; $display("FAIL frame_err_pulse: high cycles=%0d want 1", ferr_cnt - f0);
    end
    checks++;
    if (bus_if.data_ready !== 1'b0) begin
      errors++; $display("FAIL frame_err_ready: got %b want 0", bus_if.data_ready);
    end
    read_check("hold_after_ferr");
  endtask

  task automatic test_glitch();
    int f0;
    f0 = ferr_cnt;
    @(posedge clk); #1 rxd = 1'b0;
    repeat (4) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus_if.data_ready !== 1'b0 || ferr_cnt != f0) begin
      errors++;
      $display("FAIL glitch: ready=%b ferr_pulses=%0d want 0 0", bus_if.data_ready, ferr_cnt - f0);
    end
    // receiver must be back in IDLE and accept a normal frame
    send_rx(8'hC7, 1'b1);
    @(negedge clk);
    checks++;
    if (bus_if.data_ready !== 1'b1) begin
      errors++; $display("FAIL glitch_recover: ready=%b want 1", bus_if.data_ready);
    end
    read_check("after_glitch");
  endtask

  initial begin
    test_reset();
    test_tx_single();
    test_back_to_back();
    test_rx_read();
    test_overrun_frame_err();
    test_glitch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_bus_responder.md
Name: uart_bus_responder

Overview:
- Device-side UART engine that answers the CPU memory controller's strobe handshake: rdn/wrn strobes in; data_ready/tbre/tsre status out.
- Shares the low byte of the RAM1 data bus.
- Converts byte writes into 8N1 serial frames on txd, and assembles 8N1 frames from rxd into a byte the controller can read.
- Sits between the memory-controller strobes and the board serial pins.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); minimum 8.

Ports:
- clk  input  1  system clock; all state on rising edge
- rst  input  1  asynchronous, active-low reset
- bus_data  inout  8  shared data bus low byte; driven only while rdn low, else high-Z
- rdn  input  1  read strobe, active low
- wrn  input  1  write strobe, active low; byte latched on the wrn rising edge
- data_ready  output  1  received byte waiting in the RX holding register
- tbre  output  1  TX holding register empty
- tsre  output  1  TX shift register empty (line idle)
- rx_overrun  output  1  sticky; a byte was overwritten before it was read
- frame_err  output  1  one-cycle pulse; stop bit sampled 0
- txd  output  1  serial out, idle high
- rxd  input  1  serial in, asynchronous

Behaviour:
- Reset, asynchronous, all outputs:
  - txd=1, data_ready=0, tbre=1, tsre=1, rx_overrun=0, frame_err=0.
  - bus_data high-Z; RX/TX state machines IDLE; all counters 0.
  - Reset mid-frame aborts the frame: txd=1 immediately; the partial RX byte is discarded.
- Synchronisation:
  - rdn, wrn and rxd each pass through a 2-FF synchroniser. Edges are detected on the synchronised copies.
  - Exception: the bus output enable uses raw rdn combinationally, so data is valid for the whole low phase.
- Read:
  - While rdn=0, bus_data = rx_hold.
  - On the synchronised rdn rising edge: data_ready<=0 and rx_overrun<=0.
- Write:
  - On the synchronised wrn rising edge: tx_hold<=bus_data and tbre<=0.
  - The initiator holds bus_data stable for at least 3 clk after raw wrn rises.
  - Write while tbre=0: tx_hold is overwritten; the previous byte is lost and no flag is raised.
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE: if tbre=0, then shift<=tx_hold, tbre<=1, tsre<=0, go to START. This takes one cycle after tbre falls.
  - START: txd=0 for CLKS_PER_BIT cycles.
  - DATA: shift bits 0..7 LSB first, CLKS_PER_BIT cycles each; 3-bit bit counter.
  - STOP: txd=1 for CLKS_PER_BIT cycles. Then, if tbre=0, load the next byte and go straight to START (back-to-back); else tsre<=1 and go to IDLE.
  - Frame length: exactly 10*CLKS_PER_BIT cycles.
  - A write in the same cycle as the holding-to-shift load: the load takes the old tx_hold, then the new byte lands and tbre ends 0.
- RX FSM, states IDLE, START, DATA, STOP:
  - IDLE: wait for synchronised rxd falling edge.
  - START: at CLKS_PER_BIT/2 (integer division), resample. If rxd=1, it is a glitch: return to IDLE. Else advance.
  - DATA: sample 8 bits at full CLKS_PER_BIT spacing, LSB first.
  - STOP: sample the stop bit at mid-bit.
    - Stop=1: rx_hold<=byte, data_ready<=1; if data_ready was already 1 and is not being cleared this cycle, rx_overrun<=1.
    - Stop=0: frame_err pulses 1 cycle; rx_hold and data_ready are unchanged.
  - After STOP, return to IDLE; a new start bit is accepted immediately.
  - Read-clear and byte completion in the same cycle: data_ready stays 1, rx_hold holds the new byte, rx_overrun=0.
- Baud counters:
  - Width is clog2(CLKS_PER_BIT); wrap to 0 at CLKS_PER_BIT-1.
  - TX and RX counters are independent.

Test Plan (bench CLKS_PER_BIT=16):
- Reset with rxd=1, rdn=wrn=1 -> txd=1, tbre=1, tsre=1, data_ready=0, bus_data=Z. Assert rst low mid-TX frame -> txd=1 the same cycle.
- Write 8'hA5 (wrn low 4 clk) -> tbre=0 then 1 within 4 clk of wrn rise; tsre=0. txd sequence, 16 clk each: 0,1,0,1,0,0,1,0,1,1. tsre=1 exactly 160 clk after frame start.
- Write 8'h3C, then 8'hC3 while the first frame is shifting -> second frame starts immediately after the first stop bit with no idle gap; tsre stays 0 for 320 clk.
- Drive rxd frame 8'h5A -> data_ready=1 after the stop sample. rdn low reads bus_data=8'h5A; after rdn rises, data_ready=0 within 3 clk.
- Two rxd frames (8'h11, 8'h22) with no read -> rx_overrun=1, read returns 8'h22. Stop bit 0 on a third frame -> frame_err 1-cycle pulse; rx_hold remains 8'h22.
- 4-clk low glitch on rxd -> no data_ready, no frame_err, RX returns to IDLE.
